// File: rtl/mem_lsu.sv
`timescale 1ns/1ps
// MEM-stage load/store unit: drives the req/ack data bus and aligns load data for writeback.
// Latency: non-memory ops pass through combinationally; memory ops take >= 2 cycles (issue, DONE).
// Backpressure: stallreq_o is held while a bus transaction is outstanding; bus timeout aborts after TIMEOUT cycles.
module mem_lsu #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [31:0] mem_mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    input  logic        flush_i,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_ack_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_sel_o,
    output logic [4:0]  wb_wd_o,
    output logic        wb_wreg_o,
    output logic [31:0] wb_wdata_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_buf;
    logic [31:0]        r_addr;
    logic               r_we;
    logic [3:0]         r_sel;
    logic [31:0]        r_wdata;
    logic [7:0]         r_op;
    logic               r_err;

    logic               w_is_load;
    logic               w_is_store;
    logic [1:0]         w_size;      // 0 byte, 1 halfword, 2 word
    logic               w_misalign;
    logic [3:0]         w_sel;
    logic [31:0]        w_lane_wdata;
    logic               w_timeout;
    logic               w_issue;
    logic               w_capture;
    logic               w_set_err;
    logic               w_cnt_inc;

    // Pick the addressed byte/halfword out of the bus word and extend it per opcode.
    function automatic logic [31:0] load_extend(input logic [7:0] op, input logic [1:0] lo,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = d[{lo, 3'b000} +: 8];
        h   = d[{lo[1], 4'b0000} +: 16];
        res = d;
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'd0, h};
            default: res = d;
        endcase
        return res;
    endfunction

    // Decode the EX/MEM opcode into access kind and size.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = 2'd0;
        case (mem_aluop_i)
            OP_LB, OP_LBU: begin w_is_load  = 1'b1; w_size = 2'd0; end
            OP_LH, OP_LHU: begin w_is_load  = 1'b1; w_size = 2'd1; end
            OP_LW:         begin w_is_load  = 1'b1; w_size = 2'd2; end
            OP_SB:         begin w_is_store = 1'b1; w_size = 2'd0; end
            OP_SH:         begin w_is_store = 1'b1; w_size = 2'd1; end
            OP_SW:         begin w_is_store = 1'b1; w_size = 2'd2; end
            default: ;
        endcase
    end

    assign w_misalign = ((w_size == 2'd1) && mem_mem_addr_i[0]) ||
                        ((w_size == 2'd2) && (mem_mem_addr_i[1:0] != 2'b00));
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT));

    // Byte-lane enables and lane-replicated store data; loads share the lane rule.
    always_comb begin
        w_sel        = 4'b1111;
        w_lane_wdata = mem_reg2_i;
        case (w_size)
            2'd0: begin
                w_sel        = 4'b0001 << mem_mem_addr_i[1:0];
                w_lane_wdata = {4{mem_reg2_i[7:0]}};
            end
            2'd1: begin
                w_sel        = mem_mem_addr_i[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{mem_reg2_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Next-state and output logic; everything is held quiet while reset is asserted.
    always_comb begin
        w_next       = r_state;
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = 32'd0;
        dbus_wdata_o = 32'd0;
        dbus_sel_o   = 4'd0;
        wb_wd_o      = 5'd0;
        wb_wreg_o    = 1'b0;
        wb_wdata_o   = 32'd0;
        stallreq_o   = 1'b0;
        misalign_o   = 1'b0;
        bus_err_o    = 1'b0;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        w_set_err    = 1'b0;
        w_cnt_inc    = 1'b0;
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    if (flush_i) begin
                        w_next = S_IDLE;
                    end else if (!(w_is_load || w_is_store)) begin
                        wb_wd_o    = mem_wd_i;
                        wb_wreg_o  = mem_wreg_i;
                        wb_wdata_o = mem_wdata_i;
                    end else if (w_misalign) begin
                        misalign_o = 1'b1;
                    end else begin
                        w_issue      = 1'b1;
                        dbus_req_o   = 1'b1;
                        dbus_we_o    = w_is_store;
                        dbus_addr_o  = {mem_mem_addr_i[31:2], 2'b00};
                        dbus_wdata_o = w_lane_wdata;
                        dbus_sel_o   = w_sel;
                        stallreq_o   = 1'b1;
                        if (dbus_ack_i) begin
                            w_capture = 1'b1;
                            w_next    = S_DONE;
                        end else begin
                            w_next    = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    stallreq_o = 1'b1;
                    if (w_timeout) begin
                        // Request is withdrawn on the abort cycle; a flushed op aborts silently.
                        bus_err_o = !flush_i;
                        w_set_err = 1'b1;
                        w_next    = flush_i ? S_IDLE : S_DONE;
                    end else begin
                        dbus_req_o   = 1'b1;
                        dbus_we_o    = r_we;
                        dbus_addr_o  = {r_addr[31:2], 2'b00};
                        dbus_wdata_o = r_wdata;
                        dbus_sel_o   = r_sel;
                        if (dbus_ack_i) begin
                            w_capture = 1'b1;
                            w_next    = flush_i ? S_IDLE : S_DONE;
                        end else begin
                            w_cnt_inc = 1'b1;
                            w_next    = flush_i ? S_DRAIN : S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    w_next = S_IDLE;
                    if (!flush_i && r_op[3] == 1'b0 && !r_err) begin
                        wb_wd_o    = mem_wd_i;
                        wb_wreg_o  = mem_wreg_i;
                        wb_wdata_o = load_extend(r_op, r_addr[1:0], r_buf);
                    end
                end
                S_DRAIN: begin
                    stallreq_o = 1'b1;
                    if (w_timeout) begin
                        w_next = S_IDLE;
                    end else begin
                        dbus_req_o   = 1'b1;
                        dbus_we_o    = r_we;
                        dbus_addr_o  = {r_addr[31:2], 2'b00};
                        dbus_wdata_o = r_wdata;
                        dbus_sel_o   = r_sel;
                        if (dbus_ack_i) begin
                            w_next    = S_IDLE;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State, timeout counter and the transaction snapshot held stable across WAIT/DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_buf   <= 32'd0;
            r_addr  <= 32'd0;
            r_we    <= 1'b0;
            r_sel   <= 4'd0;
            r_wdata <= 32'd0;
            r_op    <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_inc ? r_cnt + 1'b1 : '0;
            if (w_issue) begin
                r_addr  <= mem_mem_addr_i;
                r_we    <= w_is_store;
                r_sel   <= w_sel;
                r_wdata <= w_lane_wdata;
                r_op    <= mem_aluop_i;
                r_err   <= 1'b0;
            end
            if (w_capture) begin
                r_buf <= dbus_rdata_i;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
`timescale 1ns/1ps
module tb_mem_lsu;

    localparam int TMO = 4;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i;
    logic [31:0] mem_wdata_i;
    logic [7:0]  mem_aluop_i;
    logic [31:0] mem_mem_addr_i;
    logic [31:0] mem_reg2_i;
    logic        flush_i;
    logic [31:0] dbus_rdata_i;
    logic        dbus_ack_i;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_sel_o;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic        stallreq_o, misalign_o, bus_err_o;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
        .mem_aluop_i(mem_aluop_i), .mem_mem_addr_i(mem_mem_addr_i), .mem_reg2_i(mem_reg2_i),
        .flush_i(flush_i), .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_sel_o(dbus_sel_o),
        .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
        .stallreq_o(stallreq_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        mis;
        logic        berr;
        int          nreq;
        int          nstall;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    int       dly_q[$];
    int       total = 0;
    int       bad = 0;
    logic     mon_en = 1'b0;

    logic [7:0]  refmem[int];   // reference byte memory
    logic [31:0] busmem[int];   // responder word memory

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (refmem.exists(int'(a))) return refmem[int'(a)];
        w = init_word({a[31:2], 2'b00});
        return w[8*int'(a[1:0]) +: 8];
    endfunction

    // Bus responder: acks after the requested number of extra cycles; -1 never acks.
    initial begin
        int cnt;
        int d;
        logic [31:0] w;
        int key;
        cnt = 0;
        d = -1;
        dbus_ack_i = 1'b0;
        dbus_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            dbus_ack_i = 1'b0;
            if (rst && dbus_req_o) begin
                if (cnt == 0) d = (dly_q.size() > 0) ? dly_q.pop_front() : -1;
                if (cnt == d) begin
                    key = int'(dbus_addr_o);
                    w = busmem.exists(key) ? busmem[key] : init_word(dbus_addr_o);
                    if (dbus_we_o) begin
                        for (int k = 0; k < 4; k++)
                            if (dbus_sel_o[k]) w[8*k +: 8] = dbus_wdata_o[8*k +: 8];
                        busmem[key] = w;
                        dbus_rdata_i = $urandom;
                    end else begin
                        dbus_rdata_i = w;
                    end
                    dbus_ack_i = 1'b1;
                end
                cnt++;
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: checks each new bus request and each retiring instruction against the queues.
    int          m_nreq = 0, m_nstall = 0;
    logic        m_berr = 1'b0, m_wrbad = 1'b0, m_preq = 1'b0;
    logic [31:0] m_paddr, m_pwdata;
    logic [3:0]  m_psel;
    logic        m_pwe;
    initial begin
        bus_exp_t be;
        wb_exp_t  we;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en) begin
                m_nreq = 0; m_nstall = 0; m_berr = 1'b0; m_wrbad = 1'b0; m_preq = 1'b0;
            end else begin
                if (dbus_req_o) begin
                    m_nreq++;
                    if (!m_preq) begin
                        if (bus_q.size() == 0) begin
                            chk("unexpected_req", 32'd1, 32'd0);
                        end else begin
                            be = bus_q.pop_front();
                            chk("bus_addr", dbus_addr_o, be.addr);
                            chk("bus_we", {31'd0, dbus_we_o}, {31'd0, be.we});
                            chk("bus_sel", {28'd0, dbus_sel_o}, {28'd0, be.sel});
                            if (be.we) chk("bus_wdata", dbus_wdata_o, be.wdata);
                        end
                    end else begin
                        chk("hold_addr", dbus_addr_o, m_paddr);
                        chk("hold_sel", {28'd0, dbus_sel_o}, {28'd0, m_psel});
                        chk("hold_we", {31'd0, dbus_we_o}, {31'd0, m_pwe});
                        chk("hold_wdata", dbus_wdata_o, m_pwdata);
                    end
                    m_paddr = dbus_addr_o; m_psel = dbus_sel_o;
                    m_pwe = dbus_we_o; m_pwdata = dbus_wdata_o;
                end
                m_preq = dbus_req_o;
                if (bus_err_o) m_berr = 1'b1;
                if (stallreq_o) begin
                    m_nstall++;
                    if (wb_wreg_o) m_wrbad = 1'b1;
                end else begin
                    if (wb_q.size() == 0) begin
                        chk("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        we = wb_q.pop_front();
                        chk("wb_wreg", {31'd0, wb_wreg_o}, {31'd0, we.wreg});
                        if (we.wreg) begin
                            chk("wb_wd", {27'd0, wb_wd_o}, {27'd0, we.wd});
                            chk("wb_wdata", wb_wdata_o, we.wdata);
                        end
                        chk("misalign", {31'd0, misalign_o}, {31'd0, we.mis});
                        chk("bus_err", {31'd0, m_berr}, {31'd0, we.berr});
                        chk("req_cycles", m_nreq, we.nreq);
                        chk("stall_cycles", m_nstall, we.nstall);
                        chk("wreg_while_stalled", {31'd0, m_wrbad}, 32'd0);
                    end
                    m_nreq = 0; m_nstall = 0; m_berr = 1'b0; m_wrbad = 1'b0;
                end
            end
        end
    end

    task automatic wait_retire();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            #2;
            if (!stallreq_o) done = 1'b1;
        end
        if (!done) chk("retire_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and derive its expected outcome from the byte-memory model.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                         input logic wr, input int dly);
        wb_exp_t  e;
        bus_exp_t b;
        int       size;
        logic     is_ld, is_st, sgn;
        longint   v;
        int       s;
        size  = 0;
        is_ld = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
        is_st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        sgn   = (op == OP_LB) || (op == OP_LH);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) size = 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) size = 2;
        if (op == OP_LW || op == OP_SW) size = 4;
        e.wd = 5'($urandom_range(31, 0));
        e.wdata = $urandom;
        e.wreg = wr;
        e.mis = 1'b0; e.berr = 1'b0; e.nreq = 0; e.nstall = 0;
        if (is_ld || is_st) begin
            if (int'(a % 32'(size)) != 0) begin
                e.mis = 1'b1;
                e.wreg = 1'b0;
            end else begin
                s = ((1 << size) - 1) << int'(a[1:0]);
                b.addr = {a[31:2], 2'b00};
                b.we = is_st;
                b.sel = s[3:0];
                for (int k = 0; k < 4; k++) b.wdata[8*k +: 8] = r2[8*(k % size) +: 8];
                bus_q.push_back(b);
                dly_q.push_back(dly);
                if (dly < 0) begin
                    e.berr = 1'b1; e.wreg = 1'b0; e.nreq = TMO + 1; e.nstall = TMO + 2;
                end else begin
                    e.nreq = dly + 1; e.nstall = dly + 1;
                    if (is_st) begin
                        e.wreg = 1'b0;
                        for (int k = 0; k < size; k++) refmem[int'(a) + k] = r2[8*k +: 8];
                    end else begin
                        v = 0;
                        for (int k = 0; k < size; k++)
                            v = v + (longint'(ref_byte(a + 32'(k))) << (8 * k));
                        if (sgn && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
                        e.wdata = v[31:0];
                    end
                end
            end
        end
        wb_q.push_back(e);
        mem_aluop_i = op; mem_mem_addr_i = a; mem_reg2_i = r2;
        mem_wreg_i = wr; mem_wd_i = e.wd;
        mem_wdata_i = (is_ld || is_st) ? $urandom : e.wdata;
        wait_retire();
    endtask

    logic [7:0] ops[9] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 8'h25};

    initial begin
        wb_exp_t  e;
        bus_exp_t b;
        rst = 1'b0; flush_i = 1'b0;
        mem_aluop_i = OP_LW; mem_mem_addr_i = 32'h100; mem_reg2_i = 32'd0;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd3; mem_wdata_i = 32'h1234;
        #12;
        chk("rst_req", {31'd0, dbus_req_o}, 32'd0);
        chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
        chk("rst_wreg", {31'd0, wb_wreg_o}, 32'd0);
        chk("rst_wd", {27'd0, wb_wd_o}, 32'd0);
        chk("rst_wdata", wb_wdata_o, 32'd0);
        chk("rst_flags", {30'd0, misalign_o, bus_err_o}, 32'd0);
        mem_aluop_i = 8'h00;
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;

        issue(OP_SW,  32'h100, 32'hDEADBEEF, 1'b1, 1);
        issue(OP_LW,  32'h100, 32'h0, 1'b1, 3);
        issue(OP_SW,  32'h100, 32'h80112233, 1'b1, 0);
        issue(OP_LB,  32'h103, 32'h0, 1'b1, 0);
        issue(OP_LBU, 32'h103, 32'h0, 1'b1, 0);
        issue(OP_SH,  32'h202, 32'h0000ABCD, 1'b1, 2);
        issue(OP_LHU, 32'h202, 32'h0, 1'b1, 1);
        issue(OP_LW,  32'h101, 32'h0, 1'b1, 0);
        issue(OP_LW,  32'h104, 32'h0, 1'b1, -1);
        issue(8'h21,  32'h0, 32'h0, 1'b1, 0);

        for (int i = 0; i < 200; i++) begin
            int d;
            d = ($urandom_range(9, 0) == 0) ? -1 : int'($urandom_range(TMO, 0));
            issue(ops[$urandom_range(8, 0)], 32'h100 + 32'($urandom_range(63, 0)),
                  $urandom, 1'($urandom_range(1, 0)), d);
        end

        // Flush while waiting: the load is drained, the replacing op passes through.
        b.addr = 32'h100; b.we = 1'b0; b.sel = 4'hF; b.wdata = 32'd0;
        bus_q.push_back(b);
        dly_q.push_back(3);
        e.wreg = 1'b1; e.wd = 5'd7; e.wdata = 32'h00001234;
        e.mis = 1'b0; e.berr = 1'b0; e.nreq = 4; e.nstall = 4;
        wb_q.push_back(e);
        mem_aluop_i = OP_LW; mem_mem_addr_i = 32'h100; mem_wreg_i = 1'b1; mem_wd_i = 5'd9;
        @(posedge clk); #1;
        flush_i = 1'b1;
        mem_aluop_i = 8'h25; mem_wd_i = 5'd7; mem_wdata_i = 32'h1234; mem_wreg_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        wait_retire();

        // Reset in the middle of a wait drops the request at once.
        b.addr = 32'h108; b.we = 1'b0; b.sel = 4'hF;
        bus_q.push_back(b);
        dly_q.push_back(-1);
        mem_aluop_i = OP_LW; mem_mem_addr_i = 32'h108;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("mid_wait_req", {31'd0, dbus_req_o}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, dbus_req_o}, 32'd0);
        chk("async_rst_stall", {31'd0, stallreq_o}, 32'd0);
        mon_en = 1'b0;
        chk("wb_q_left", wb_q.size(), 32'd0);
        chk("bus_q_left", bus_q.size(), 32'd0);
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs (wd, wreg, wdata, aluop, mem_addr, reg2).
- Drives a req/ack data bus with byte-lane selects, aligns and sign/zero-extends load data, and presents writeback info to MEM/WB.
- Requests a pipeline stall while a bus transaction is outstanding; flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255, WAIT-state cycles without dbus_ack_i before the access is aborted with bus_err_o.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active low (`RstEnable == 0), acts on negedge rst.
- mem_wd_i  in  `RegAddrBus  destination register from EX/MEM.
- mem_wreg_i  in  1  writeback enable from EX/MEM.
- mem_wdata_i  in  `RegBus  ALU result from EX/MEM.
- mem_aluop_i  in  `AluOpBus  operation code (EXE_LB/LH/LW/LBU/LHU/SB/SH/SW; anything else is non-memory).
- mem_mem_addr_i  in  `DataAddrBus  effective byte address.
- mem_reg2_i  in  `RegBus  store source data.
- flush_i  in  1  pipeline flush for the MEM stage (flush[3]).
- dbus_rdata_i  in  32  read data, valid when dbus_ack_i=1.
- dbus_ack_i  in  1  transaction complete (one-cycle pulse).
- dbus_req_o  out  1  transaction request, held until ack.
- dbus_we_o  out  1  1=store, 0=load.
- dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- dbus_wdata_o  out  32  lane-replicated store data.
- dbus_sel_o  out  4  byte-lane enables.
- wb_wd_o  out  `RegAddrBus  to MEM/WB.
- wb_wreg_o  out  1  to MEM/WB.
- wb_wdata_o  out  `RegBus  to MEM/WB.
- stallreq_o  out  1  stall request to the pipeline controller.
- misalign_o  out  1  one-cycle misaligned-access flag.
- bus_err_o  out  1  one-cycle timeout flag.

Behaviour:
- States: IDLE, WAIT, DONE, DRAIN. Reset: state=IDLE, counter=0, load buffer=`ZeroWord. Outputs at reset: dbus_req_o=0, stallreq_o=0, misalign_o=0, bus_err_o=0, wb_wreg_o=`WriteDisable, wb_wd_o=`NOPRegAddr, wb_wdata_o=`ZeroWord.
- Non-memory op in IDLE: combinational pass-through of wd/wreg/wdata; no request; stallreq_o=0.
- Alignment: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0. On violation: no request, misalign_o=1 for that cycle, wb_wreg_o=0, no stall, state stays IDLE.
- Aligned memory op in IDLE: dbus_req_o=1 and stallreq_o=1 combinationally. If dbus_ack_i=1 in the same cycle, capture data and go to DONE; otherwise go to WAIT.
- WAIT: req, addr, we, sel and wdata held stable. Counter increments each cycle. On ack, capture and go to DONE. When counter reaches TIMEOUT without ack: drop req, pulse bus_err_o, go to DONE with wb_wreg_o forced to 0.
- DONE: stallreq_o=0, dbus_req_o=0. Load: wb_wdata_o=extended buffer and wb_wreg_o=mem_wreg_i. Store: wb_wreg_o=0. Next state IDLE, counter cleared. A memory access therefore costs at least 2 cycles.
- Store lanes:
  - SB: wdata={4{reg2[7:0]}}, sel=4'b0001<<addr[1:0].
  - SH: wdata={2{reg2[15:0]}}, sel=addr[1]?1100:0011.
  - SW: wdata=reg2, sel=1111.
- Load extract: LB/LBU take byte addr[1:0]; LH/LHU take halfword addr[1]. LB/LH sign-extend, LBU/LHU zero-extend. Load sel uses the same lane rule as stores.
- Flush: in IDLE or DONE, flush_i drops the req and outputs NOP writeback. In WAIT, flush_i moves to DRAIN.
- DRAIN: req held until ack or timeout (no bus_err_o pulse in DRAIN). stallreq_o=1, wb_wreg_o=0. Then IDLE.
- Async reset mid-transaction: immediately IDLE, req dropped.

Test Plan:
- LW addr=0x100, ack after 3 WAIT cycles, rdata=0xDEADBEEF -> req high 4 cycles, stallreq high 4 cycles, DONE cycle wb_wdata_o=0xDEADBEEF, wb_wreg_o=1.
- LB addr=0x103, zero-wait ack, rdata=0x80112233 -> sel=1000, wb_wdata_o=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr=0x202, reg2=0x0000ABCD -> dbus_we_o=1, sel=1100, dbus_wdata_o=0xABCDABCD, addr=0x200, wb_wreg_o=0.
- LW addr=0x101 -> no req, misalign_o=1 one cycle, wb_wreg_o=0, stallreq_o=0.
- LW with ack never asserted, TIMEOUT=4 -> req for 5 cycles, bus_err_o pulse, wb_wreg_o=0, return to IDLE.
- flush_i during WAIT, ack 2 cycles later -> DRAIN, req held until ack, no writeback; rst low mid-WAIT -> req=0 immediately.
